// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between NUM_REQ byte requesters, the round-robin
// arbiter and the downstream UART transmitter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 grant_valid;
    logic [ID_W-1:0]      grant_id;
    logic                 abort;

    // Requesters plus the UART side: they drive requests and tx_ready.
    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_data, tx_valid, grant_valid, grant_id, abort
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_data, tx_valid, grant_valid, grant_id, abort
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of a UART transmitter.
// A requester keeps the byte stream from grant until its req_last byte, so
// packets never interleave. A grant whose holder goes quiet for IDLE_TIMEOUT
// cycles is forcibly released with a one-cycle abort pulse.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.slave  bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    // Counter value at which one more quiet cycle completes the timeout.
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
    // Pointer starts at the top index so requester 0 is scanned first.
    localparam logic [ID_W-1:0]  PTR_RESET = ID_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ID_W-1:0]    grant_id_q;
    logic [ID_W-1:0]    last_ptr_q;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    cand;
    logic               any_req;
    logic [CNT_W-1:0]   idle_cnt_q;
    logic [7:0]         tx_data_q;
    logic               tx_valid_q;
    logic               abort_q;
    logic               slot_free;
    logic               xfer;
    logic               xfer_last;
    logic               timeout_hit;
    logic [NUM_REQ-1:0] req_ready_c;
    logic [7:0]         grant_data;

    // The output register can accept a new byte when empty or draining now.
    assign slot_free = !tx_valid_q || bus.tx_ready;

    // Round-robin pick: first valid requester after the last packet owner.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_ptr_q) + k) % NUM_REQ);
            if (!any_req && bus.req_valid[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

    // Byte presented by the current grant holder.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == ID_W'(i)) begin
                grant_data = bus.req_data[8*i +: 8];
            end
        end
    end

    // Next state, holder's ready, and the transfer/release events.
    always_comb begin
        state_next  = state;
        req_ready_c = '0;
        xfer        = 1'b0;
        xfer_last   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                req_ready_c[grant_id_q] = slot_free;
                xfer      = bus.req_valid[grant_id_q] && slot_free;
                xfer_last = xfer && bus.req_last[grant_id_q];
                if (xfer_last) begin
                    state_next = IDLE;
                end else if ((IDLE_TIMEOUT > 0) && !bus.req_valid[grant_id_q]
                             && (idle_cnt_q == CNT_LAST)) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant holder, round-robin pointer and quiet-cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_id_q <= '0;
            last_ptr_q <= PTR_RESET;
            idle_cnt_q <= '0;
        end else if (state == IDLE) begin
            if (any_req) begin
                grant_id_q <= winner;
                idle_cnt_q <= '0;
            end
        end else if (xfer_last || timeout_hit) begin
            last_ptr_q <= grant_id_q;
            grant_id_q <= '0;
            idle_cnt_q <= '0;
        end else if (xfer) begin
            idle_cnt_q <= '0;
        end else if (!bus.req_valid[grant_id_q]) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
        end
    end

    // Single output stage; a byte may load while the previous one drains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else if (xfer) begin
            tx_data_q  <= grant_data;
            tx_valid_q <= 1'b1;
        end else if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
        end
    end

    // One-cycle abort pulse marking a timeout release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            abort_q <= 1'b0;
        end else begin
            abort_q <= timeout_hit;
        end
    end

    assign bus.req_ready   = req_ready_c;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.grant_valid = (state == LOCKED);
    assign bus.grant_id    = grant_id_q;
    assign bus.abort       = abort_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed latency, round-robin,
// backpressure, timeout and reset sequences, an arbitration vector table,
// and a randomized packet stream checked by a packet-level scoreboard.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 16;

    localparam logic [7:0] EXP2_DATA [6] = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h31, 8'h32};
    localparam int         EXP2_CYC  [6] = '{2, 3, 5, 6, 8, 9};

    typedef struct {
        int                 prev;
        logic [NUM_REQ-1:0] mask;
        int                 exp_winner;
    } arb_vec_t;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .IDLE_TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    logic [8:0]         src_q [NUM_REQ][$];
    int                 gap_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] popped = '0;
    logic               gaps_enabled = 1'b0;
    int                 tx_ready_mode = 0;
    logic               abort_allowed = 1'b0;
    logic               prev_stall = 1'b0;
    logic [7:0]         prev_data = '0;
    logic [7:0]         rx_q [$];
    int                 rx_cyc [$];

    logic               s_grant_valid;
    logic [1:0]         s_grant_id;
    logic [3:0]         s_req_ready;
    logic               s_tx_valid;
    logic [7:0]         s_tx_data;
    logic               s_abort;
    logic [3:0]         s_xfer;
    int                 s_cycle;

    logic               rand_mon = 1'b0;
    logic [7:0]         exp_bytes [NUM_REQ][$];
    int                 exp_len [NUM_REQ][$];
    int                 cur_src = 0;
    int                 cur_rem = 0;
    int                 pkts_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        checks++;
        errors++;
        $display("[TB] FAIL %s: %s", name, why);
    endtask

    // Push a packet of len incrementing bytes starting at first.
    task automatic enqueue(input int src, input logic [7:0] first, input int len);
        for (int k = 0; k < len; k++) begin
            src_q[src].push_back({(k == len - 1) ? 1'b1 : 1'b0, first + 8'(k)});
        end
    endtask

    function automatic logic all_empty();
        logic e;
        e = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic clear_tb_state();
        for (int i = 0; i < NUM_REQ; i++) begin
            src_q[i].delete();
            gap_cnt[i] = 0;
        end
        popped     = '0;
        prev_stall = 1'b0;
        rx_q.delete();
        rx_cyc.delete();
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
    endtask

    // Randomized-run scoreboard: source id lives in byte bits [7:6].
    task automatic rand_check(input logic [7:0] b);
        int s;
        s = int'(b[7:6]);
        if (cur_rem == 0) begin
            if (exp_len[s].size() == 0) begin
                fail_now("rand_pkt_start", $sformatf("byte 0x%0h from source %0d with no packet pending", b, s));
                return;
            end
            cur_src = s;
            cur_rem = exp_len[s].pop_front();
        end else begin
            check("rand_contiguous", 32'(s), 32'(cur_src));
        end
        if (exp_bytes[s].size() == 0) begin
            fail_now("rand_byte_extra", $sformatf("byte 0x%0h beyond expected data", b));
        end else begin
            check("rand_byte", 32'(b), 32'(exp_bytes[s].pop_front()));
        end
        cur_rem--;
        if (cur_rem == 0) pkts_done++;
    endtask

    // Drive requester and UART inputs for the coming cycle.
    task automatic apply_stimulus();
        logic [NUM_REQ-1:0]   v;
        logic [NUM_REQ-1:0]   l;
        logic [8*NUM_REQ-1:0] d;
        v = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (popped[i] && src_q[i].size() > 0) begin
                void'(src_q[i].pop_front());
                if (gaps_enabled && $urandom_range(0, 3) == 0) gap_cnt[i] = int'($urandom_range(1, 3));
            end
            if (gap_cnt[i] > 0) begin
                gap_cnt[i]--;
            end else if (src_q[i].size() > 0) begin
                v[i]          = 1'b1;
                l[i]          = src_q[i][0][8];
                d[8*i +: 8]   = src_q[i][0][7:0];
            end
        end
        popped        = '0;
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
        case (tx_ready_mode)
            1:       bus.tx_ready = 1'($urandom_range(0, 1));
            2:       bus.tx_ready = 1'b0;
            default: bus.tx_ready = 1'b1;
        endcase
    endtask

    // Sample outputs mid-cycle and apply the always-true protocol rules.
    task automatic check_output();
        s_grant_valid = bus.grant_valid;
        s_grant_id    = bus.grant_id;
        s_req_ready   = bus.req_ready;
        s_tx_valid    = bus.tx_valid;
        s_tx_data     = bus.tx_data;
        s_abort       = bus.abort;
        s_cycle       = cycle;
        s_xfer        = bus.req_valid & bus.req_ready;
        popped        = s_xfer;
        check("ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
        if (!bus.grant_valid) check("grant_id_idle", 32'(bus.grant_id), 32'd0);
        if (prev_stall) begin
            check("tx_hold_valid", 32'(bus.tx_valid), 32'd1);
            check("tx_hold_data", 32'(bus.tx_data), 32'(prev_data));
        end
        prev_stall = bus.tx_valid && !bus.tx_ready;
        prev_data  = bus.tx_data;
        if (!abort_allowed) check("abort_quiet", 32'(bus.abort), 32'd0);
        if (bus.tx_valid && bus.tx_ready) begin
            rx_q.push_back(bus.tx_data);
            rx_cyc.push_back(cycle);
            if (rand_mon) rand_check(bus.tx_data);
        end
    endtask

    task automatic tick();
        apply_stimulus();
        @(negedge clk);
        check_output();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int   n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            tick();
            n++;
            done = all_empty() && !s_tx_valid && !s_grant_valid;
        end
        check({name, "_drain"}, 32'(done), 32'd1);
    endtask

    task automatic reset_dut();
        clear_tb_state();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_rx(input string name, input int idx, input logic [7:0] exp);
        if (idx < rx_q.size()) check(name, 32'(rx_q[idx]), 32'(exp));
        else fail_now(name, $sformatf("byte %0d never received, expected 0x%0h", idx, exp));
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        arb_vec_t vecs [9];
        int       t0;
        int       t_xfer;
        int       ab_first;
        int       ab_cnt;
        int       off;
        int       left;
        logic     gv_at [40];
        logic [1:0] gid_at [40];
        logic [5:0] seq [NUM_REQ];

        vecs[0] = '{3, 4'b1111, 0};
        vecs[1] = '{0, 4'b1111, 1};
        vecs[2] = '{1, 4'b1001, 3};
        vecs[3] = '{2, 4'b0100, 2};
        vecs[4] = '{3, 4'b0110, 1};
        vecs[5] = '{0, 4'b0001, 0};
        vecs[6] = '{1, 4'b0101, 2};
        vecs[7] = '{2, 4'b0011, 0};
        vecs[8] = '{3, 4'b1000, 3};

        reset        = 1'b1;
        bus.tx_ready = 1'b1;
        clear_tb_state();
        @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_grant_valid", 32'(bus.grant_valid), 32'd0);
        check("rst_grant_id", 32'(bus.grant_id), 32'd0);
        check("rst_abort", 32'(bus.abort), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] arbitration vector table");
        for (int v = 0; v < 9; v++) begin
            enqueue(vecs[v].prev, 8'hE0, 1);
            run_until_idle("vec_prev", 50);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (vecs[v].mask[i]) enqueue(i, 8'hC0 + 8'(i), 1);
            end
            tick();
            tick();
            check($sformatf("vec%0d_grant_valid", v), 32'(s_grant_valid), 32'd1);
            check($sformatf("vec%0d_winner", v), 32'(s_grant_id), 32'(vecs[v].exp_winner));
            run_until_idle("vec_flush", 50);
        end

        $display("[TB] single source latency");
        rx_q.delete();
        rx_cyc.delete();
        enqueue(2, 8'hA1, 3);
        t0 = cycle;
        tick();
        check("t1_c0_grant_valid", 32'(s_grant_valid), 32'd0);
        check("t1_c0_req_ready", 32'(s_req_ready), 32'd0);
        tick();
        check("t1_c1_grant_valid", 32'(s_grant_valid), 32'd1);
        check("t1_c1_grant_id", 32'(s_grant_id), 32'd2);
        check("t1_c1_req_ready", 32'(s_req_ready), 32'b0100);
        run_until_idle("t1", 50);
        check("t1_count", 32'(rx_q.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check_rx("t1_byte", k, 8'hA1 + 8'(k));
            if (k < rx_cyc.size()) check("t1_cycle", 32'(rx_cyc[k] - t0), 32'(k + 2));
        end

        $display("[TB] round robin");
        reset_dut();
        for (int round = 0; round < 2; round++) begin
            rx_q.delete();
            rx_cyc.delete();
            enqueue(0, 8'h01, 2);
            enqueue(1, 8'h11, 2);
            enqueue(3, 8'h31, 2);
            t0 = cycle;
            run_until_idle("t2", 100);
            check("t2_count", 32'(rx_q.size()), 32'd6);
            for (int k = 0; k < 6; k++) begin
                check_rx("t2_byte", k, EXP2_DATA[k]);
                if (k < rx_cyc.size()) check("t2_cycle", 32'(rx_cyc[k] - t0), 32'(EXP2_CYC[k]));
            end
        end

        $display("[TB] backpressure");
        rx_q.delete();
        rx_cyc.delete();
        tx_ready_mode = 2;
        enqueue(1, 8'h51, 4);
        tick();
        tick();
        for (int n = 0; n < 50; n++) begin
            tick();
            check("t3_tx_valid", 32'(s_tx_valid), 32'd1);
            check("t3_tx_data", 32'(s_tx_data), 32'h51);
            check("t3_req_ready", 32'(s_req_ready), 32'd0);
            check("t3_grant", 32'({s_grant_valid, s_grant_id}), 32'b101);
        end
        tx_ready_mode = 0;
        run_until_idle("t3", 50);
        check("t3_count", 32'(rx_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) check_rx("t3_byte", k, 8'h51 + 8'(k));

        $display("[TB] idle timeout");
        rx_q.delete();
        rx_cyc.delete();
        abort_allowed = 1'b1;
        src_q[1].push_back({1'b0, 8'h61});
        t_xfer = -1;
        for (int n = 0; n < 10 && t_xfer < 0; n++) begin
            tick();
            if (s_xfer[1]) t_xfer = s_cycle;
        end
        check("t4_xfer_seen", 32'(t_xfer >= 0), 32'd1);
        enqueue(2, 8'h71, 1);
        for (int k = 0; k < 40; k++) begin
            gv_at[k]  = 1'b0;
            gid_at[k] = '0;
        end
        ab_first = -1;
        ab_cnt   = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            off = s_cycle - t_xfer;
            if (off >= 0 && off < 40) begin
                gv_at[off]  = s_grant_valid;
                gid_at[off] = s_grant_id;
            end
            if (s_abort) begin
                ab_cnt++;
                if (ab_first < 0) ab_first = off;
            end
        end
        // Abort rises on the 16th clock edge after the transfer edge.
        check("t4_abort_offset", 32'(ab_first), 32'd17);
        check("t4_abort_width", 32'(ab_cnt), 32'd1);
        check("t4_still_locked", 32'({gv_at[16], gid_at[16]}), 32'b101);
        check("t4_released", 32'(gv_at[17]), 32'd0);
        check("t4_next_grant", 32'({gv_at[18], gid_at[18]}), 32'b110);
        run_until_idle("t4", 50);
        check("t4_count", 32'(rx_q.size()), 32'd2);
        check_rx("t4_byte0", 0, 8'h61);
        check_rx("t4_byte1", 1, 8'h71);
        abort_allowed = 1'b0;

        $display("[TB] async reset mid-packet");
        enqueue(3, 8'h81, 8);
        for (int n = 0; n < 10 && !s_tx_valid; n++) tick();
        check("t5_txv_before", 32'(s_tx_valid), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("t5_req_ready", 32'(bus.req_ready), 32'd0);
        check("t5_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("t5_tx_data", 32'(bus.tx_data), 32'd0);
        check("t5_grant_valid", 32'(bus.grant_valid), 32'd0);
        check("t5_grant_id", 32'(bus.grant_id), 32'd0);
        check("t5_abort", 32'(bus.abort), 32'd0);
        clear_tb_state();
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        enqueue(3, 8'h93, 1);
        enqueue(0, 8'h90, 1);
        tick();
        tick();
        check("t5_first_grant", 32'({s_grant_valid, s_grant_id}), 32'b100);
        run_until_idle("t5", 50);
        check("t5_count", 32'(rx_q.size()), 32'd2);
        check_rx("t5_byte0", 0, 8'h90);
        check_rx("t5_byte1", 1, 8'h93);

        $display("[TB] random packets");
        rx_q.delete();
        rx_cyc.delete();
        for (int i = 0; i < NUM_REQ; i++) seq[i] = '0;
        for (int p = 0; p < 100; p++) begin
            int s;
            int len;
            s   = int'($urandom_range(0, NUM_REQ - 1));
            len = int'($urandom_range(1, 16));
            exp_len[s].push_back(len);
            for (int k = 0; k < len; k++) begin
                logic [7:0] b;
                b = {2'(s), seq[s]};
                seq[s] = seq[s] + 6'd1;
                exp_bytes[s].push_back(b);
                src_q[s].push_back({(k == len - 1) ? 1'b1 : 1'b0, b});
            end
        end
        gaps_enabled  = 1'b1;
        tx_ready_mode = 1;
        rand_mon      = 1'b1;
        cur_rem       = 0;
        pkts_done     = 0;
        run_until_idle("t6", 20000);
        check("t6_packets", 32'(pkts_done), 32'd100);
        left = 0;
        for (int i = 0; i < NUM_REQ; i++) left += exp_bytes[i].size();
        check("t6_leftover", 32'(left), 32'd0);
        rand_mon      = 1'b0;
        gaps_enabled  = 1'b0;
        tx_ready_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
